morv_lsu: RTL and testbench

Multi-cycle load/store unit between the morv core's execute stage and the memory bus. It replaces single-cycle combinational memory access with a request/response handshake, proper `ready` wait states, a bus timeout, and alignment checks. Data width is parametrised for RV32 (32) or RV64 (64) buses. The core issues one access at a time and stalls on `req_ready`/`rsp_valid`.

---
 rtl/morv_lsu.sv | 274 +++++++++++++++++++++++++++
 tb/tb_morv_lsu.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/morv_lsu.sv
// morv_lsu: multi-cycle load/store unit between the morv execute stage and a ready-handshaked memory bus.
// Latency: illegal/misaligned rejects respond 1 cycle after accept; bus accesses respond 1 cycle after the last beat's ready.
// Backpressure: req_ready only in IDLE (one access in flight); each bus beat holds until ready or TIMEOUT wait cycles.
//
// Ports: clk/rst_n (async active-low); req_* core request (valid/ready); rsp_* one-cycle response pulse;
//        busy = not IDLE; mem_valid/address/wdata/write/wstrb bus request, rdata/ready bus completion.
// Optional: define MORV_LSU_MISALIGNED_SPLIT_EN to perform misaligned accesses (split into two beats
//           when they cross an NB-byte word) instead of rejecting them with cause 01.
module morv_lsu #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic [1:0]          rsp_cause,
  output logic                busy,
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W-1:0]   wdata,
  output logic                write,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                ready
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_MIS  = 2'b01;
  localparam logic [1:0] C_TO   = 2'b10;
  localparam logic [1:0] C_ILL  = 2'b11;

`ifdef MORV_LSU_MISALIGNED_SPLIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2, ACCESS2 = 2'd3} state_t;
  // Lane mask spans two words: low half is beat 1, high half is beat 2.
  localparam int MW = 2 * NB;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  localparam int MW = NB;
`endif

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          cause_q, cause_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                write_q;
  logic [2:0]          f3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic [3:0]          size_q;
  logic [OFF_W-1:0]    off_q;
  logic [ADDR_W-1:0]   base_q;
  logic [MW-1:0]       lane_mask;
  logic [DATA_W-1:0]   wdata_rep;
  logic [DATA_W-1:0]   beat_wdata;
  logic                in_beat2;
  logic                to_hit;

  function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b011:                 ok = (DATA_W == 64);
      3'b100, 3'b101:         ok = !wr;
      3'b110:                 ok = !wr && (DATA_W == 64);
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] a, input logic [2:0] f3);
    logic [2:0] m;
    case (f3[1:0])
      2'd0:    m = 3'b000;
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b011;
      default: m = 3'b111;
    endcase
    return |(a & m);
  endfunction

  // Byte i of the result is byte (i+off) of the two-word window {hi_w, lo_w}.
  function automatic logic [DATA_W-1:0] gather(input logic [DATA_W-1:0] lo_w,
                                               input logic [DATA_W-1:0] hi_w,
                                               input logic [OFF_W-1:0]  off);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      if (i + int'(off) < NB) r[8*i +: 8] = lo_w[8*(i + int'(off)) +: 8];
      else                    r[8*i +: 8] = hi_w[8*(i + int'(off) - NB) +: 8];
    end
    return r;
  endfunction

  // Keep the low (8 << f3[1:0]) bits; sign-extend unless unsigned or full width.
  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v, input logic [2:0] f3);
    logic [DATA_W-1:0] r;
    logic              sb;
    int                bits;
    bits = 8 << f3[1:0];
    case (f3[1:0])
      2'd0:    sb = v[7];
      2'd1:    sb = v[15];
      2'd2:    sb = v[31];
      default: sb = v[DATA_W-1];
    endcase
    if (f3[2] || bits >= DATA_W) sb = 1'b0;
    for (int i = 0; i < DATA_W; i++) r[i] = (i < bits) ? v[i] : sb;
    return r;
  endfunction

  assign size_q = 4'd1 << f3_q[1:0];
  assign off_q  = addr_q[OFF_W-1:0];
  assign base_q = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    lane_mask = '0;
    wdata_rep = '0;
    for (int i = 0; i < MW; i++)
      lane_mask[i] = (i >= int'(off_q)) && (i < int'(off_q) + int'(size_q));
    for (int i = 0; i < NB; i++)
      wdata_rep[8*i +: 8] = wdata_q[8*(i & (int'(size_q) - 1)) +: 8];
  end

`ifdef MORV_LSU_MISALIGNED_SPLIT_EN
  logic [DATA_W-1:0] beat1_q, beat1_d;
  logic [DATA_W-1:0] wdata_rot;
  logic              crosses;

  // Misaligned stores rotate the value so byte k lands in lane (off+k) mod NB,
  // which serves both beats: beat 1 uses the upper lanes, beat 2 the lower ones.
  always_comb begin
    wdata_rot = '0;
    for (int i = 0; i < NB; i++)
      wdata_rot[8*i +: 8] = wdata_q[8*((i - int'(off_q)) & (NB - 1)) +: 8];
  end

  assign crosses    = (int'(off_q) + int'(size_q)) > NB;
  assign beat_wdata = misaligned(addr_q[2:0], f3_q) ? wdata_rot : wdata_rep;
  assign in_beat2   = (state_q == ACCESS2);
`else
  assign beat_wdata = wdata_rep;
  assign in_beat2   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    rsp_data_d = rsp_data_q;
`ifdef MORV_LSU_MISALIGNED_SPLIT_EN
    beat1_d    = beat1_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rsp_data_d = '0;
          cnt_d      = '0;
          if (!f3_legal(req_write, req_funct3)) begin
            cause_d = C_ILL;
            state_d = RESP;
          end
`ifndef MORV_LSU_MISALIGNED_SPLIT_EN
          else if (misaligned(req_addr[2:0], req_funct3)) begin
            cause_d = C_MIS;
            state_d = RESP;
          end
`endif
          else begin
            cause_d = C_NONE;
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // ready on the same cycle as the final timeout count still completes the beat
        if (ready) begin
`ifdef MORV_LSU_MISALIGNED_SPLIT_EN
          if (crosses) begin
            beat1_d = rdata;
            cnt_d   = '0;
            state_d = ACCESS2;
          end else
`endif
          begin
            rsp_data_d = write_q ? '0 : extend(gather(rdata, '0, off_q), f3_q);
            state_d    = RESP;
          end
        end else if (to_hit) begin
          cause_d = C_TO;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef MORV_LSU_MISALIGNED_SPLIT_EN
      ACCESS2: begin
        if (ready) begin
          rsp_data_d = write_q ? '0 : extend(gather(beat1_q, rdata, off_q), f3_q);
          state_d    = RESP;
        end else if (to_hit) begin
          cause_d = C_TO;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cause_q    <= C_NONE;
      rsp_data_q <= '0;
      write_q    <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef MORV_LSU_MISALIGNED_SPLIT_EN
      beat1_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      rsp_data_q <= rsp_data_d;
`ifdef MORV_LSU_MISALIGNED_SPLIT_EN
      beat1_q    <= beat1_d;
`endif
      if (req_valid && req_ready) begin
        write_q <= req_write;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  // All bus and response outputs decode from state only, so reset clears them without a clock.
  assign req_ready = (state_q == IDLE);
  assign busy      = !req_ready;
  assign mem_valid = (state_q == ACCESS) || in_beat2;
  assign address   = !mem_valid ? '0 : (in_beat2 ? base_q + ADDR_W'(NB) : base_q);
  assign write     = mem_valid && write_q;
  assign wdata     = mem_valid ? beat_wdata : '0;
  assign wstrb     = !(mem_valid && write_q) ? '0 :
                     (in_beat2 ? lane_mask[MW-1 -: NB] : lane_mask[NB-1:0]);

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_valid ? rsp_data_q : '0;
  assign rsp_cause = rsp_valid ? cause_q : C_NONE;
  assign rsp_err   = rsp_valid && (cause_q != C_NONE);

endmodule

// File: tb/tb_morv_lsu.sv
// tb_morv_lsu: randomized bench for morv_lsu (32-bit bus, TIMEOUT=4) against a byte-level reference model.
// Latency: responses are checked for exact cycle position relative to request accept.
// Backpressure: bus ready wait states are randomized per beat, including waits past the timeout.
module tb_morv_lsu;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NB      = 4;
  localparam int TIMEOUT = 4;
`ifdef MORV_LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_write;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr, req_wdata;
  logic              rsp_valid, rsp_err, busy;
  logic [31:0]       rsp_data;
  logic [1:0]        rsp_cause;
  logic              mem_valid, write, ready;
  logic [31:0]       address, wdata, rdata;
  logic [3:0]        wstrb;

  morv_lsu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_cause(rsp_cause),
    .busy(busy), .mem_valid(mem_valid), .address(address), .wdata(wdata),
    .write(write), .wstrb(wstrb), .rdata(rdata), .ready(ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference expectations for the access in flight.
  int          e_nbeats, e_mv, e_lat;
  logic [31:0] e_addr[2], e_wdat[2], e_bmask[2], e_data;
  logic [3:0]  e_strb[2];
  logic [1:0]  e_cause;

  // Works byte by byte: each accessed byte lives in some word, the words become beats.
  task automatic model(input bit wr, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                       input int wt0, input int wt1, input bit [31:0] rd0, input bit [31:0] rd1);
    int size, nb, wt[2], bt, ln;
    bit legal, mis;
    bit [31:0] v, ba, rd[2];
    wt[0] = wt0; wt[1] = wt1; rd[0] = rd0; rd[1] = rd1;
    size  = 1 << f3[1:0];
    legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis   = (a % size) != 0;
    e_nbeats = 0; e_mv = 0; e_data = 0; e_cause = 2'd0; e_lat = 1; v = 0;
    for (int b = 0; b < 2; b++) begin
      e_strb[b] = 0; e_wdat[b] = 0; e_bmask[b] = 0;
    end
    e_addr[0] = a & ~32'h3;
    e_addr[1] = e_addr[0] + 32'd4;
    if (!legal) e_cause = 2'd3;
    else if (mis && !SPLIT) e_cause = 2'd1;
    else begin
      nb = ((a % NB) + size > NB) ? 2 : 1;
      for (int k = 0; k < size; k++) begin
        ba = a + k;
        bt = ((ba & ~32'h3) == e_addr[0]) ? 0 : 1;
        ln = ba % NB;
        if (wr) e_strb[bt][ln] = 1'b1;
        e_bmask[bt][8*ln +: 8] = 8'hFF;
        e_wdat[bt][8*ln +: 8]  = wd[8*k +: 8];
        v[8*k +: 8]            = rd[bt][8*ln +: 8];
      end
      if (!mis) begin
        // aligned stores replicate the value across every lane
        e_bmask[0] = 32'hFFFF_FFFF;
        for (int i = 0; i < NB; i++) e_wdat[0][8*i +: 8] = wd[8*(i % size) +: 8];
      end
      for (int b = 0; b < nb; b++) begin
        e_nbeats++;
        if (wt[b] >= TIMEOUT) begin
          e_mv += TIMEOUT; e_lat += TIMEOUT; e_cause = 2'd2;
          break;
        end
        e_mv += wt[b] + 1; e_lat += wt[b] + 1;
      end
      if (e_cause == 2'd0 && !wr) begin
        if (size < 4 && !f3[2] && v[8*size-1]) v = v - (32'd1 << (8*size));
        e_data = v;
      end
    end
  endtask

  // Issues one request, plays the bus with wt0/wt1 wait cycles per beat, checks everything.
  task automatic run(input bit wr, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                     input int wt0, input int wt1, input bit [31:0] rd0, input bit [31:0] rd1,
                     output logic [31:0] got);
    int wt[2], cyc, b, bi, w, mv, nbeat;
    bit seen, rdy;
    bit [31:0] rd[2];
    wt[0] = wt0; wt[1] = wt1; rd[0] = rd0; rd[1] = rd1;
    model(wr, f3, a, wd, wt0, wt1, rd0, rd1);
    got = 'x;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    ready = 1'($urandom_range(0, 1));
    rdata = $urandom;
    @(negedge clk);
    // scramble request fields: the LSU must work from its latched copy
    req_valid = 1'b0; req_write = 1'($urandom_range(0, 1)); req_funct3 = 3'($urandom_range(0, 7));
    req_addr = $urandom; req_wdata = $urandom;
    cyc = 1; b = 0; w = 0; mv = 0; nbeat = 0; seen = 0;
    while (cyc <= 40 && !seen) begin
      if (rsp_valid) begin
        seen = 1;
        got  = rsp_data;
        chk("rsp_latency", cyc, e_lat);
        chk("rsp_data", rsp_data, e_data);
        chk("rsp_err", rsp_err, e_cause != 2'd0);
        chk("rsp_cause", rsp_cause, e_cause);
        chk("mem_valid_in_rsp", mem_valid, 1'b0);
      end else begin
        bi  = (b > 1) ? 1 : b;
        rdy = 0;
        if (mem_valid) begin
          mv++;
          if (w == 0) nbeat++;
          chk("bus_address", address, e_addr[bi]);
          chk("bus_write", write, wr);
          chk("bus_wstrb", wstrb, e_strb[bi]);
          if (wr) chk("bus_wdata", wdata & e_bmask[bi], e_wdat[bi]);
          rdy = (w == wt[bi]);
          w++;
        end
        ready = rdy;
        rdata = rdy ? rd[bi] : $urandom;
        @(negedge clk);
        cyc++;
        if (rdy) begin b++; w = 0; end
      end
    end
    ready = 1'b0;
    chk("rsp_seen", seen, 1'b1);
    chk("mem_valid_cycles", mv, e_mv);
    chk("bus_beats", nbeat, e_nbeats);
    ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid, 1'b0);
    chk("rsp_data_idle", rsp_data, 32'd0);
    chk("req_ready_after", req_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] got, a;
    bit          wr;
    bit [2:0]    f3;
    int          w0, w1;

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; ready = 1'b0; rdata = 32'd0;
    #2;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_outputs", {address, wdata, write, wstrb, rsp_data, rsp_err, rsp_cause}, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // LW aligned, zero wait
    run(0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 32'h0, got);
    chk("lw_value", got, 32'hDEADBEEF);
    // LB / LBU from the top lane
    run(0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80123456, 32'h0, got);
    chk("lb_value", got, 32'hFFFFFF80);
    run(0, 3'b100, 32'h103, 32'h0, 1, 0, 32'h80123456, 32'h0, got);
    chk("lbu_value", got, 32'h00000080);
    // SH upper half
    run(1, 3'b001, 32'h202, 32'h1234BEEF, 0, 0, 32'h0, 32'h0, got);
    chk("sh_rsp_data", got, 32'd0);
    // misaligned LW crossing a word
    run(0, 3'b010, 32'h1001, 32'h0, 0, 0, 32'hAABBCCDD, 32'h11223344, got);
`ifdef MORV_LSU_MISALIGNED_SPLIT_EN
    chk("split_lw_value", got, 32'h44AABBCC);
`else
    chk("mis_lw_value", got, 32'd0);
`endif
    // timeout, then ready on the last allowed cycle
    run(0, 3'b010, 32'h300, 32'h0, TIMEOUT, 0, 32'h5, 32'h0, got);
    run(0, 3'b010, 32'h300, 32'h0, TIMEOUT - 1, 0, 32'h12345678, 32'h0, got);
    chk("late_ready_value", got, 32'h12345678);
    // illegal funct3
    run(0, 3'b111, 32'h400, 32'h0, 0, 0, 32'h0, 32'h0, got);

    // reset in the middle of an access
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h40; ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_access_mem_valid", mem_valid, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_mem_valid", mem_valid, 1'b0);
    chk("async_rst_req_ready", req_ready, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", rsp_valid, 1'b0);
      chk("post_rst_idle", req_ready, 1'b1);
    end
    run(0, 3'b001, 32'h42, 32'h0, TIMEOUT - 1, 0, 32'h7FFF0000, 32'h0, got);

    // random traffic
    for (int n = 0; n < 200; n++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom_range(0, 255);
      if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFF8 + (a & 32'h7);
      w0 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 1));
      w1 = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 1));
      run(wr, f3, a, $urandom, w0, w1, $urandom, $urandom, got);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
